// File: rtl/mvm_sequencer.sv
// mvm_sequencer
// Sequences one sparse matrix-vector job: buffers host entries in a small
// FIFO, issues them to the MVM datapath at most once every two cycles,
// signals the end of the entry list, collects OUT_LEN result words (with a
// watchdog) and streams them back to the host over a valid/ready port.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          host entry handshake
//   in_value/in_row/in_col     entry value and coordinates
//   in_last                    final entry of the job
//   acc_value/acc_row/acc_col  registered entry towards the datapath
//   acc_sending                one-cycle strobe, acc_* valid
//   acc_done_list              one-cycle strobe, entry list complete
//   acc_fetch_ready            datapath can take an entry
//   acc_sending_out/acc_out    result word from the datapath
//   res_valid/res_ready        result stream handshake
//   res_data/res_idx           result word and its index
//   busy                       job in progress
//   err                        sticky result-timeout flag
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | no job; entries accepted, first one starts a job
// ISSUE     | entries accepted and issued to the datapath
// LIST_DONE | all entries issued; pulse acc_done_list
// WAIT_OUT  | collecting result words, watchdog running
// STREAM    | presenting result words to the host
//
// res_idx is two bits wide, so OUT_LEN may be at most 4.
module mvm_sequencer #(
   parameter int         FIFO_DEPTH = 4,
   parameter logic [7:0] TIMEOUT    = 8'd255,
   parameter int         OUT_LEN    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_value,
   input  logic [1:0] in_row,
   input  logic [1:0] in_col,
   input  logic       in_last,
   output logic [7:0] acc_value,
   output logic [1:0] acc_row,
   output logic [1:0] acc_col,
   output logic       acc_sending,
   output logic       acc_done_list,
   input  logic       acc_fetch_ready,
   input  logic       acc_sending_out,
   input  logic [7:0] acc_out,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [7:0] res_data,
   output logic [1:0] res_idx,
   output logic       busy,
   output logic       err
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      LIST_DONE = 3'd2,
      WAIT_OUT  = 3'd3,
      STREAM    = 3'd4
   } state_t;

   state_t         state_q, state_d;
   logic [11:0]    mem_q [FIFO_DEPTH];
   logic [11:0]    mem_d [FIFO_DEPTH];
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic           last_q, last_d;
   logic           init_q, init_d;
   logic           err_q, err_d;
   logic [7:0]     acc_value_q, acc_value_d;
   logic [1:0]     acc_row_q, acc_row_d;
   logic [1:0]     acc_col_q, acc_col_d;
   logic           acc_sending_q, acc_sending_d;
   logic           acc_done_list_q, acc_done_list_d;
   logic [7:0]     tmo_q, tmo_d;
   logic [1:0]     widx_q, widx_d;
   logic [7:0]     rbuf_q [4];
   logic [7:0]     rbuf_d [4];
   logic           res_valid_q, res_valid_d;
   logic [7:0]     res_data_q, res_data_d;
   logic [1:0]     res_idx_q, res_idx_d;

   logic fifo_full;
   logic push;
   logic pop;

   assign fifo_full = (count_q == CW'(FIFO_DEPTH));

   // init_q keeps in_ready low while in reset and for the first cycle after.
   assign in_ready = init_q && !fifo_full && !last_q &&
                     ((state_q == IDLE) || (state_q == ISSUE));

   assign push = in_valid && in_ready;
   // acc_sending_q blocks back-to-back issues.
   assign pop  = (state_q == ISSUE) && (count_q != '0) &&
                 acc_fetch_ready && !acc_sending_q;

   always_comb begin
      state_d         = state_q;
      mem_d           = mem_q;
      wr_ptr_d        = wr_ptr_q;
      rd_ptr_d        = rd_ptr_q;
      count_d         = count_q;
      last_d          = last_q;
      init_d          = 1'b1;
      err_d           = err_q;
      acc_value_d     = acc_value_q;
      acc_row_d       = acc_row_q;
      acc_col_d       = acc_col_q;
      acc_sending_d   = 1'b0;
      acc_done_list_d = 1'b0;
      tmo_d           = tmo_q;
      widx_d          = widx_q;
      rbuf_d          = rbuf_q;
      res_valid_d     = res_valid_q;
      res_data_d      = res_data_q;
      res_idx_d       = res_idx_q;

      if (push) begin
         mem_d[wr_ptr_q] = {in_value, in_row, in_col};
         wr_ptr_d        = wr_ptr_q + PW'(1);
         if (in_last) begin
            last_d = 1'b1;
         end
      end

      if (pop) begin
         {acc_value_d, acc_row_d, acc_col_d} = mem_q[rd_ptr_q];
         rd_ptr_d      = rd_ptr_q + PW'(1);
         acc_sending_d = 1'b1;
      end

      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end

      case (state_q)
         IDLE: begin
            if (push) begin
               state_d = ISSUE;
               err_d   = 1'b0;
            end
         end
         ISSUE: begin
            if (last_q && (count_q == '0) && !acc_sending_q) begin
               state_d         = LIST_DONE;
               acc_done_list_d = 1'b1;
            end
         end
         LIST_DONE: begin
            state_d = WAIT_OUT;
            tmo_d   = '0;
            widx_d  = '0;
         end
         WAIT_OUT: begin
            if (acc_sending_out) begin
               rbuf_d[widx_q] = acc_out;
               widx_d         = widx_q + 2'd1;
               tmo_d          = '0;
               if (widx_q == 2'(OUT_LEN - 1)) begin
                  state_d     = STREAM;
                  res_valid_d = 1'b1;
                  res_idx_d   = '0;
                  // With a single-word job the word is still in flight.
                  res_data_d  = (widx_q == 2'd0) ? acc_out : rbuf_q[0];
               end
            end else if ((tmo_q + 8'd1) == TIMEOUT) begin
               err_d    = 1'b1;
               wr_ptr_d = '0;
               rd_ptr_d = '0;
               count_d  = '0;
               last_d   = 1'b0;
               state_d  = IDLE;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         STREAM: begin
            if (res_ready) begin
               if (res_idx_q == 2'(OUT_LEN - 1)) begin
                  res_valid_d = 1'b0;
                  res_idx_d   = '0;
                  res_data_d  = '0;
                  last_d      = 1'b0;
                  state_d     = IDLE;
               end else begin
                  res_idx_d  = res_idx_q + 2'd1;
                  res_data_d = rbuf_q[res_idx_q + 2'd1];
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
         last_q          <= 1'b0;
         init_q          <= 1'b0;
         err_q           <= 1'b0;
         acc_value_q     <= '0;
         acc_row_q       <= '0;
         acc_col_q       <= '0;
         acc_sending_q   <= 1'b0;
         acc_done_list_q <= 1'b0;
         tmo_q           <= '0;
         widx_q          <= '0;
         for (int i = 0; i < 4; i++) begin
            rbuf_q[i] <= '0;
         end
         res_valid_q     <= 1'b0;
         res_data_q      <= '0;
         res_idx_q       <= '0;
      end else begin
         state_q         <= state_d;
         mem_q           <= mem_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         count_q         <= count_d;
         last_q          <= last_d;
         init_q          <= init_d;
         err_q           <= err_d;
         acc_value_q     <= acc_value_d;
         acc_row_q       <= acc_row_d;
         acc_col_q       <= acc_col_d;
         acc_sending_q   <= acc_sending_d;
         acc_done_list_q <= acc_done_list_d;
         tmo_q           <= tmo_d;
         widx_q          <= widx_d;
         rbuf_q          <= rbuf_d;
         res_valid_q     <= res_valid_d;
         res_data_q      <= res_data_d;
         res_idx_q       <= res_idx_d;
      end
   end

   assign acc_value     = acc_value_q;
   assign acc_row       = acc_row_q;
   assign acc_col       = acc_col_q;
   assign acc_sending   = acc_sending_q;
   assign acc_done_list = acc_done_list_q;
   assign res_valid     = res_valid_q;
   assign res_data      = res_data_q;
   assign res_idx       = res_idx_q;
   assign busy          = (state_q != IDLE);
   assign err           = err_q;

endmodule
